// File: rtl/ex_operand_stage_pkg.sv
// Shared types and helpers for the execute operand stage: ALU encodings,
// forwarding-source enum and the register-dependency check.
package ex_operand_stage_pkg;

`include "alu_op.vh"

    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_EX   = 2'd1,
        SRC_WB   = 2'd2,
        SRC_RF   = 2'd3
    } fwd_src_e;

    // True when a consumed source register is still being produced downstream.
    function automatic logic rs_conflict(
        input reg_idx_t idx,
        input logic     used,
        input reg_idx_t ex_rd,
        input reg_idx_t wb_rd
    );
        return used && (idx != '0) && ((idx == ex_rd) || (idx == wb_rd));
    endfunction

endpackage

// File: rtl/alu_op.vh
// ALU operation codes and operand-select bit positions, included by
// ex_operand_stage_pkg so every stage sees one definition.
`ifndef ALU_OP_VH
`define ALU_OP_VH

typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10,
    ALU_COPY = 4'd11
} alu_op_e;

// in_op_sel bit positions: set bit picks pc for A, imm for B.
localparam int OP_SEL_A_PC  = 0;
localparam int OP_SEL_B_IMM = 1;

`endif

// File: rtl/ex_operand_stage_fwd_mux.sv
// Resolves one source register value: x0 -> 0, else youngest in-flight
// producer (ALU stage, then writeback) when FORWARD_EN, else register file.
module fwd_mux
    import ex_operand_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [REG_IDX_W-1:0] rs_idx,
    input  logic [DATA_W-1:0]    rf_data,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic [DATA_W-1:0]    ex_data,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [DATA_W-1:0]    wb_data,
    output logic [DATA_W-1:0]    operand
);

    fwd_src_e src;

`ifdef FORWARD_EN
    always_comb begin
        src = SRC_RF;
        if (rs_idx == '0) begin
            src = SRC_ZERO;
        end else if (rs_idx == ex_rd) begin
            src = SRC_EX;
        end else if (rs_idx == wb_rd) begin
            src = SRC_WB;
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{ex_rd, ex_data, wb_rd, wb_data};

    always_comb begin
        src = (rs_idx == '0) ? SRC_ZERO : SRC_RF;
    end
`endif

    always_comb begin
        operand = '0;
        case (src)
            SRC_ZERO: operand = '0;
            SRC_EX:   operand = ex_data;
            SRC_WB:   operand = wb_data;
            SRC_RF:   operand = rf_data;
            default:  operand = '0;
        endcase
    end

endmodule

// File: rtl/ex_operand_stage.sv
// One-entry registered operand stage feeding the ALU. FORWARD_EN selects
// ex/wb bypassing; without it, dependent entries are interlocked at the input.
module ex_operand_stage
    import ex_operand_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_rs1_addr,
    input  logic [4:0]        in_rs2_addr,
    input  logic [DATA_W-1:0] in_rs1_data,
    input  logic [DATA_W-1:0] in_rs2_data,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [1:0]        in_op_sel,
    input  logic [3:0]        in_alu_sel,
    input  logic [4:0]        in_rd_addr,
    input  logic [4:0]        ex_rd,
    input  logic [DATA_W-1:0] ex_data,
    input  logic [4:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [3:0]        out_alu_sel,
    output logic [4:0]        out_rd_addr
);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // in_ready never depends on in_valid; out_* are held while out_valid && !out_ready.

    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;
    logic              interlock;
    logic              capture;

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [3:0]        alu_q, alu_d;
    logic [4:0]        rd_q, rd_d;

    fwd_mux #(.DATA_W(DATA_W)) u_fwd_rs1 (
        .rs_idx  (in_rs1_addr),
        .rf_data (in_rs1_data),
        .ex_rd   (ex_rd),
        .ex_data (ex_data),
        .wb_rd   (wb_rd),
        .wb_data (wb_data),
        .operand (rs1_val)
    );

    fwd_mux #(.DATA_W(DATA_W)) u_fwd_rs2 (
        .rs_idx  (in_rs2_addr),
        .rf_data (in_rs2_data),
        .ex_rd   (ex_rd),
        .ex_data (ex_data),
        .wb_rd   (wb_rd),
        .wb_data (wb_data),
        .operand (rs2_val)
    );

`ifdef FORWARD_EN
    assign interlock = 1'b0;
`else
    // A source only counts as consumed when the select bit routes it to the ALU.
    assign interlock =
        rs_conflict(in_rs1_addr, !in_op_sel[OP_SEL_A_PC],  ex_rd, wb_rd) ||
        rs_conflict(in_rs2_addr, !in_op_sel[OP_SEL_B_IMM], ex_rd, wb_rd);
`endif

    assign in_ready = (!valid_q || out_ready) && !interlock;
    assign capture  = in_valid && in_ready && !flush;

    always_comb begin
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        alu_d   = alu_q;
        rd_d    = rd_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d = 1'b1;
            a_d     = in_op_sel[OP_SEL_A_PC]  ? in_pc  : rs1_val;
            b_d     = in_op_sel[OP_SEL_B_IMM] ? in_imm : rs2_val;
            alu_d   = in_alu_sel;
            rd_d    = in_rd_addr;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            rd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            rd_q    <= rd_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_a       = a_q;
    assign out_b       = b_q;
    assign out_alu_sel = alu_q;
    assign out_rd_addr = rd_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Testbench for ex_operand_stage: directed corner cases plus randomized
// traffic checked against a queue-based reference model.
module tb_ex_operand_stage;

    localparam int DATA_W = 32;
    localparam int EW     = 2 * DATA_W + 9;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_rs1_addr;
    logic [4:0]        in_rs2_addr;
    logic [DATA_W-1:0] in_rs1_data;
    logic [DATA_W-1:0] in_rs2_data;
    logic [DATA_W-1:0] in_pc;
    logic [DATA_W-1:0] in_imm;
    logic [1:0]        in_op_sel;
    logic [3:0]        in_alu_sel;
    logic [4:0]        in_rd_addr;
    logic [4:0]        ex_rd;
    logic [DATA_W-1:0] ex_data;
    logic [4:0]        wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic [3:0]        out_alu_sel;
    logic [4:0]        out_rd_addr;

    logic [EW-1:0] exp_q[$];
    int            n_checks;
    int            n_errors;
    logic [DATA_W-1:0] held_a;

    ex_operand_stage #(.DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rs1_addr (in_rs1_addr),
        .in_rs2_addr (in_rs2_addr),
        .in_rs1_data (in_rs1_data),
        .in_rs2_data (in_rs2_data),
        .in_pc       (in_pc),
        .in_imm      (in_imm),
        .in_op_sel   (in_op_sel),
        .in_alu_sel  (in_alu_sel),
        .in_rd_addr  (in_rd_addr),
        .ex_rd       (ex_rd),
        .ex_data     (ex_data),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_alu_sel (out_alu_sel),
        .out_rd_addr (out_rd_addr)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [DATA_W-1:0] ref_operand(input logic [4:0] idx,
                                                      input logic [DATA_W-1:0] rf);
        if (idx == 5'd0) return '0;
`ifdef FORWARD_EN
        if (idx == ex_rd) return ex_data;
        if (idx == wb_rd) return wb_data;
`endif
        return rf;
    endfunction

    function automatic logic ref_ready();
        logic   room;
        logic   blocked;
        int     used_idx[$];
        room    = (exp_q.size() == 0) || out_ready;
        blocked = 1'b0;
`ifndef FORWARD_EN
        if (!in_op_sel[0]) used_idx.push_back(int'(in_rs1_addr));
        if (!in_op_sel[1]) used_idx.push_back(int'(in_rs2_addr));
        foreach (used_idx[i]) begin
            if (used_idx[i] != 0 &&
                (used_idx[i] == int'(ex_rd) || used_idx[i] == int'(wb_rd)))
                blocked = 1'b1;
        end
`endif
        return room && !blocked;
    endfunction

    function automatic logic [EW-1:0] ref_entry();
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        a = in_op_sel[0] ? in_pc  : ref_operand(in_rs1_addr, in_rs1_data);
        b = in_op_sel[1] ? in_imm : ref_operand(in_rs2_addr, in_rs2_data);
        return {a, b, in_alu_sel, in_rd_addr};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks outputs mid-cycle, then advances the model over the next rising edge.
    task automatic tick();
        logic exp_ready;
        logic fire_out;
        logic cap;
        @(negedge clk);
        exp_ready = ref_ready();
        chk("in_ready", EW'(in_ready), EW'(exp_ready));
        chk("out_valid", EW'(out_valid), EW'(exp_q.size() != 0));
        if (exp_q.size() != 0)
            chk("out_entry", {out_a, out_b, out_alu_sel, out_rd_addr}, exp_q[0]);
        fire_out = (exp_q.size() != 0) && out_ready;
        cap      = in_valid && exp_ready && !flush;
        if (flush) begin
            exp_q.delete();
        end else begin
            if (fire_out) void'(exp_q.pop_front());
            if (cap) exp_q.push_back(ref_entry());
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- drivers ----------------
    task automatic set_idle();
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_rs1_addr = '0;
        in_rs2_addr = '0;
        in_rs1_data = '0;
        in_rs2_data = '0;
        in_pc       = '0;
        in_imm      = '0;
        in_op_sel   = '0;
        in_alu_sel  = '0;
        in_rd_addr  = '0;
        ex_rd       = '0;
        ex_data     = '0;
        wb_rd       = '0;
        wb_data     = '0;
    endtask

    task automatic drive_random();
        in_valid    = ($urandom_range(0, 3) != 0);
        out_ready   = ($urandom_range(0, 3) != 0);
        flush       = ($urandom_range(0, 19) == 0);
        in_rs1_addr = 5'($urandom_range(0, 7));
        in_rs2_addr = 5'($urandom_range(0, 7));
        in_rs1_data = $urandom;
        in_rs2_data = $urandom;
        in_pc       = $urandom;
        in_imm      = $urandom;
        in_op_sel   = 2'($urandom_range(0, 3));
        in_alu_sel  = 4'($urandom_range(0, 15));
        in_rd_addr  = 5'($urandom_range(0, 31));
        ex_rd       = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
        ex_data     = $urandom;
        wb_rd       = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
        wb_data     = $urandom;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_valid"}, EW'(out_valid), '0);
        chk({tag, "_a"},     EW'(out_a),     '0);
        chk({tag, "_b"},     EW'(out_b),     '0);
        chk({tag, "_alu"},   EW'(out_alu_sel), '0);
        chk({tag, "_rd"},    EW'(out_rd_addr), '0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        set_idle();

        // reset values
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", EW'(in_ready), EW'(1'b1));

        // x0 is never forwarded, even when a producer claims index 0
        in_valid    = 1'b1;
        in_op_sel   = 2'b00;
        in_rs1_addr = 5'd0;
        in_rs2_addr = 5'd0;
        in_rs2_data = 32'h0000_1234;
        ex_rd       = 5'd0;
        ex_data     = 32'hFFFF_FFFF;
        in_alu_sel  = 4'd5;
        in_rd_addr  = 5'd9;
        tick();
        in_valid = 1'b0;
        chk("x0_out_b", EW'(out_b), '0);
        chk("x0_out_a", EW'(out_a), '0);
        tick();

`ifdef FORWARD_EN
        // ALU-stage result wins over writeback and register file
        set_idle();
        in_valid    = 1'b1;
        in_rs1_addr = 5'd3;
        in_rs1_data = 32'd5;
        ex_rd       = 5'd3;
        ex_data     = 32'd9;
        wb_rd       = 5'd3;
        wb_data     = 32'd7;
        tick();
        in_valid = 1'b0;
        chk("fwd_ex_first", EW'(out_a), EW'(32'd9));
        ex_rd    = 5'd0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("fwd_wb_second", EW'(out_a), EW'(32'd7));
        tick();
`else
        // dependent rs1 stalls until both producers are clear of x4
        set_idle();
        in_valid    = 1'b1;
        in_rs1_addr = 5'd4;
        in_rs1_data = 32'h0000_0044;
        ex_rd       = 5'd4;
        tick();
        chk("interlock_ex", EW'(in_ready), '0);
        chk("interlock_no_cap", EW'(out_valid), '0);
        ex_rd = 5'd0;
        wb_rd = 5'd4;
        tick();
        chk("interlock_wb", EW'(in_ready), '0);
        wb_rd = 5'd0;
        tick();
        in_valid = 1'b0;
        chk("interlock_release", EW'(out_a), EW'(32'h0000_0044));
        // A = pc, so x4 is not consumed and no stall occurs
        in_valid  = 1'b1;
        in_op_sel = 2'b01;
        in_pc     = 32'h0000_1000;
        ex_rd     = 5'd4;
        chk("unused_rs_no_stall", EW'(in_ready), EW'(1'b1));
        tick();
        in_valid = 1'b0;
        chk("unused_rs_out_a", EW'(out_a), EW'(32'h0000_1000));
        tick();
`endif

        // backpressure: held entry stays put, the new one waits and is not lost
        set_idle();
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        in_op_sel  = 2'b11;
        in_pc      = 32'hA000_0001;
        in_imm     = 32'hB000_0001;
        in_alu_sel = 4'd1;
        in_rd_addr = 5'd1;
        tick();
        held_a     = in_pc;
        out_ready  = 1'b0;
        in_pc      = 32'hA000_0002;
        in_imm     = 32'hB000_0002;
        in_rd_addr = 5'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_in_ready", EW'(in_ready), '0);
            chk("bp_hold_a", EW'(out_a), EW'(held_a));
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("bp_next_a", EW'(out_a), EW'(32'hA000_0002));
        chk("bp_next_rd", EW'(out_rd_addr), EW'(5'd2));

        // flush kills held entry and same-cycle incoming entry
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'hA000_0003;
        flush     = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", EW'(out_valid), '0);
        tick();
        chk("flush_nothing_cap", EW'(out_valid), '0);

        // asynchronous reset in the middle of a backpressure stall
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 32'hA000_0004;
        tick();
        out_ready = 1'b0;
        in_pc     = 32'hA000_0005;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        exp_q.delete();
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst2", EW'(in_ready), EW'(1'b1));
        tick();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive_random();
            tick();
        end

        set_idle();
        out_ready = 1'b1;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
